// File: rtl/cv32e40p_obi_instr_responder.sv
// OBI instruction-memory responder: grants fetch requests, returns words from a
// preloadable memory in grant order after a fixed minimum latency.
module cv32e40p_obi_instr_responder #(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RVALID_LATENCY  = 1,
  localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_req_i,
  input  logic [31:0]   instr_addr_i,
  output logic          instr_gnt_o,
  output logic          instr_rvalid_o,
  output logic [31:0]   instr_rdata_o,
  output logic          instr_err_o,
  input  logic          gnt_stall_i,
  input  logic          rvalid_stall_i,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_wdata_i,
  output logic [2:0]    outstanding_o
);

  // Handshake: a request transfers in any cycle with instr_req_i & instr_gnt_o;
  // each transfer yields exactly one instr_rvalid_o cycle, in grant order, and
  // the response channel has no ready (the initiator must always accept).

  // Storage is sized for the largest legal MAX_OUTSTANDING; pointers wrap at
  // MAX_OUTSTANDING so slots beyond it are never written.
  localparam int unsigned SLOTS     = 4;
  localparam logic [2:0]  MAX_CNT   = 3'(MAX_OUTSTANDING);
  localparam logic [2:0]  LAT       = 3'(RVALID_LATENCY);
  localparam logic [1:0]  LAST_SLOT = 2'(MAX_OUTSTANDING - 1);
  localparam logic [63:0] SPAN      = 64'(MEM_WORDS) * 64'd4;

  logic [31:0]      mem [MEM_WORDS];

  logic [31:0]      fifo_data [SLOTS];
  logic             fifo_err  [SLOTS];
  logic [2:0]       fifo_age  [SLOTS];
  logic [SLOTS-1:0] fifo_valid;
  logic [1:0]       head_q;
  logic [1:0]       tail_q;
  logic [2:0]       count_q;

  logic [31:0]      offset;
  logic             in_range;
  logic [AW-1:0]    word_idx;
  logic [31:0]      grant_data;
  logic             grant_err;
  logic             head_ready;
  logic             push;
  logic             pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == LAST_SLOT) ? 2'd0 : p + 2'd1;
  endfunction

  // Address decode; the byte offset within a word is dropped by the slice.
  assign offset   = instr_addr_i - BASE_ADDR;
  assign in_range = {32'd0, offset} < SPAN;
  assign word_idx = offset[AW+1:2];

  always_comb begin
    grant_data = '0;
    grant_err  = 1'b0;
    if (instr_req_i) begin
      if (in_range) grant_data = mem[word_idx];
      else          grant_err  = 1'b1;
    end
  end

  // Grant depends only on the registered count, never on a same-cycle retire.
  assign instr_gnt_o = instr_req_i & ~gnt_stall_i & (count_q < MAX_CNT);
  assign push        = instr_gnt_o;

  assign head_ready     = fifo_valid[head_q] & (fifo_age[head_q] == LAT);
  assign instr_rvalid_o = head_ready & ~rvalid_stall_i;
  assign pop            = instr_rvalid_o;
  assign instr_rdata_o  = instr_rvalid_o ? fifo_data[head_q] : 32'd0;
  assign instr_err_o    = instr_rvalid_o ? fifo_err[head_q] : 1'b0;
  assign outstanding_o  = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fifo_valid <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        fifo_data[i] <= '0;
        fifo_err[i]  <= 1'b0;
        fifo_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        if (fifo_valid[i] && (fifo_age[i] < LAT)) fifo_age[i] <= fifo_age[i] + 3'd1;
      end
      if (pop) begin
        fifo_valid[head_q] <= 1'b0;
        head_q             <= next_ptr(head_q);
      end
      // The tail slot is free whenever push is legal, so it never aliases the head.
      if (push) begin
        fifo_valid[tail_q] <= 1'b1;
        fifo_data[tail_q]  <= grant_data;
        fifo_err[tail_q]   <= grant_err;
        fifo_age[tail_q]   <= 3'd1;
        tail_q             <= next_ptr(tail_q);
      end
      if (push && !pop)      count_q <= count_q + 3'd1;
      else if (!push && pop) count_q <= count_q - 3'd1;
    end
  end

  // Memory contents survive reset; a same-edge grant already captured old data.
  always_ff @(posedge clk) begin
    if (load_we_i) mem[load_addr_i] <= load_wdata_i;
  end

endmodule

// File: tb/tb_cv32e40p_obi_instr_responder.sv
// Directed bench for the OBI instruction responder: instance A uses latency 1
// at base 0, instance B uses latency 3 with a non-zero base and 16 words.
module tb_cv32e40p_obi_instr_responder;

  localparam logic [31:0] BASE_B = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance A signals ----------------
  logic        a_req, a_gnt_stall, a_rv_stall, a_load_we;
  logic [31:0] a_addr, a_load_wdata;
  logic [9:0]  a_load_addr;
  logic        a_gnt, a_rvalid, a_err;
  logic [31:0] a_rdata;
  logic [2:0]  a_out;

  // ---------------- instance B signals ----------------
  logic        b_req, b_gnt_stall, b_rv_stall, b_load_we;
  logic [31:0] b_addr, b_load_wdata;
  logic [3:0]  b_load_addr;
  logic        b_gnt, b_rvalid, b_err;
  logic [31:0] b_rdata;
  logic [2:0]  b_out;

  cv32e40p_obi_instr_responder #(
    .MEM_WORDS(1024), .BASE_ADDR(32'h0), .MAX_OUTSTANDING(2), .RVALID_LATENCY(1)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(a_req), .instr_addr_i(a_addr), .instr_gnt_o(a_gnt),
    .instr_rvalid_o(a_rvalid), .instr_rdata_o(a_rdata), .instr_err_o(a_err),
    .gnt_stall_i(a_gnt_stall), .rvalid_stall_i(a_rv_stall),
    .load_we_i(a_load_we), .load_addr_i(a_load_addr), .load_wdata_i(a_load_wdata),
    .outstanding_o(a_out)
  );

  cv32e40p_obi_instr_responder #(
    .MEM_WORDS(16), .BASE_ADDR(BASE_B), .MAX_OUTSTANDING(2), .RVALID_LATENCY(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .instr_req_i(b_req), .instr_addr_i(b_addr), .instr_gnt_o(b_gnt),
    .instr_rvalid_o(b_rvalid), .instr_rdata_o(b_rdata), .instr_err_o(b_err),
    .gnt_stall_i(b_gnt_stall), .rvalid_stall_i(b_rv_stall),
    .load_we_i(b_load_we), .load_addr_i(b_load_addr), .load_wdata_i(b_load_wdata),
    .outstanding_o(b_out)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task tick;
    @(posedge clk);
    #1;
  endtask

  task sample;
    @(negedge clk);
  endtask

  task automatic load_a(input logic [9:0] addr, input logic [31:0] d);
    a_load_we = 1'b1; a_load_addr = addr; a_load_wdata = d;
    tick;
    a_load_we = 1'b0;
  endtask

  task automatic load_b(input logic [3:0] addr, input logic [31:0] d);
    b_load_we = 1'b1; b_load_addr = addr; b_load_wdata = d;
    tick;
    b_load_we = 1'b0;
  endtask

  // Single latency-1 read on A: grant in cycle 0, response in cycle 1.
  task automatic rd_a(input string tag, input logic [31:0] addr,
                      input logic [31:0] d, input logic e);
    a_req = 1'b1; a_addr = addr;
    sample;
    chk({tag, "_gnt"}, 32'(a_gnt), 32'd1);
    tick;
    a_req = 1'b0; a_addr = 32'd0;
    sample;
    chk({tag, "_rvalid"}, 32'(a_rvalid), 32'd1);
    chk({tag, "_rdata"}, a_rdata, d);
    chk({tag, "_err"}, 32'(a_err), 32'(e));
    tick;
  endtask

  // Single latency-3 read on B: grant in cycle 0, silent 1-2, response in cycle 3.
  task automatic rd_b(input string tag, input logic [31:0] addr,
                      input logic [31:0] d, input logic e);
    b_req = 1'b1; b_addr = addr;
    sample;
    chk({tag, "_gnt"}, 32'(b_gnt), 32'd1);
    tick;
    b_req = 1'b0; b_addr = 32'd0;
    for (int c = 1; c <= 2; c++) begin
      sample;
      chk({tag, "_early"}, 32'(b_rvalid), 32'd0);
      tick;
    end
    sample;
    chk({tag, "_rvalid"}, 32'(b_rvalid), 32'd1);
    chk({tag, "_rdata"}, b_rdata, d);
    chk({tag, "_err"}, 32'(b_err), 32'(e));
    tick;
  endtask

  // Back-to-back table for B (cycle 0..8): word index, req, gnt, rvalid, count.
  int w_t   [9] = '{1, 2, 3, 3, 3, 0, 0, 0, 0};
  int req_t [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
  int gnt_t [9] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
  int rv_t  [9] = '{0, 0, 0, 1, 1, 0, 0, 1, 0};
  int out_t [9] = '{0, 1, 2, 2, 1, 1, 1, 1, 0};

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    a_req = 0; a_gnt_stall = 0; a_rv_stall = 0; a_load_we = 0;
    a_addr = 0; a_load_wdata = 0; a_load_addr = 0;
    b_req = 0; b_gnt_stall = 0; b_rv_stall = 0; b_load_we = 0;
    b_addr = 0; b_load_wdata = 0; b_load_addr = 0;

    // Reset state
    #2;
    chk("rst_rvalid", 32'(a_rvalid), 32'd0);
    chk("rst_rdata", a_rdata, 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_out", 32'(a_out), 32'd0);
    chk("rst_gnt_noreq", 32'(a_gnt), 32'd0);
    a_req = 1'b1; b_req = 1'b1;
    #1;
    chk("rst_gnt_req_a", 32'(a_gnt), 32'd1);
    chk("rst_gnt_req_b", 32'(b_gnt), 32'd1);
    a_req = 1'b0; b_req = 1'b0;

    // Preload memories
    load_a(10'd0, 32'h0000_0413);
    load_a(10'd1, 32'h1111_0001);
    load_a(10'd2, 32'h2222_0002);
    load_a(10'd3, 32'h3333_0003);
    load_a(10'd1023, 32'hDEAD_BEEF);
    load_b(4'd1, 32'hB000_0001);
    load_b(4'd2, 32'hB000_0002);
    load_b(4'd3, 32'hB000_0003);
    load_b(4'd15, 32'hBBBB_000F);
    rst_n = 1'b1;
    tick;

    // Basic latency-1 fetch, then idle afterwards
    a_req = 1'b1; a_addr = 32'h0;
    sample;
    chk("b2b_a_gnt_c0", 32'(a_gnt), 32'd1);
    chk("b2b_a_rvalid_c0", 32'(a_rvalid), 32'd0);
    tick;
    a_req = 1'b0;
    sample;
    chk("basic_rvalid", 32'(a_rvalid), 32'd1);
    chk("basic_rdata", a_rdata, 32'h0000_0413);
    chk("basic_err", 32'(a_err), 32'd0);
    chk("basic_out", 32'(a_out), 32'd1);
    tick;
    sample;
    chk("basic_idle_rvalid", 32'(a_rvalid), 32'd0);
    chk("basic_idle_rdata", a_rdata, 32'd0);
    chk("basic_idle_out", 32'(a_out), 32'd0);
    tick;

    // Low address bits ignored, top word, out-of-range above and far away
    rd_a("lowbits", 32'h0000_0007, 32'h1111_0001, 1'b0);
    rd_a("topword", 32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0);
    rd_a("oor_end", 32'h0000_1000, 32'h0, 1'b1);
    rd_a("oor_far", 32'hFFFF_FFFC, 32'h0, 1'b1);

    // Response stall holds the head for cycles 1-4
    a_req = 1'b1; a_addr = 32'h8;
    sample;
    chk("rvstall_gnt", 32'(a_gnt), 32'd1);
    tick;
    a_req = 1'b0; a_rv_stall = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      sample;
      chk("rvstall_rvalid", 32'(a_rvalid), 32'd0);
      chk("rvstall_out", 32'(a_out), 32'd1);
      tick;
    end
    a_rv_stall = 1'b0;
    sample;
    chk("rvstall_rvalid_c5", 32'(a_rvalid), 32'd1);
    chk("rvstall_rdata_c5", a_rdata, 32'h2222_0002);
    chk("rvstall_out_c5", 32'(a_out), 32'd1);
    tick;
    sample;
    chk("rvstall_out_c6", 32'(a_out), 32'd0);
    tick;

    // Grant stall for 3 cycles with a wandering address, then grant
    a_gnt_stall = 1'b1; a_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_addr = 32'(c * 4);
      sample;
      chk("gstall_gnt", 32'(a_gnt), 32'd0);
      chk("gstall_out", 32'(a_out), 32'd0);
      tick;
    end
    a_gnt_stall = 1'b0; a_addr = 32'hC;
    sample;
    chk("gstall_gnt_c3", 32'(a_gnt), 32'd1);
    chk("gstall_rvalid_c3", 32'(a_rvalid), 32'd0);
    tick;
    a_req = 1'b0;
    sample;
    chk("gstall_rvalid_c4", 32'(a_rvalid), 32'd1);
    chk("gstall_rdata_c4", a_rdata, 32'h3333_0003);
    chk("gstall_out_c4", 32'(a_out), 32'd1);
    tick;
    sample;
    chk("gstall_out_c5", 32'(a_out), 32'd0);
    tick;

    // Load and grant to the same word in one cycle return the old data
    a_req = 1'b1; a_addr = 32'h0;
    a_load_we = 1'b1; a_load_addr = 10'd0; a_load_wdata = 32'hCAFE_0000;
    sample;
    chk("wr_gnt", 32'(a_gnt), 32'd1);
    tick;
    a_req = 1'b0; a_load_we = 1'b0;
    sample;
    chk("wr_old_rdata", a_rdata, 32'h0000_0413);
    tick;
    rd_a("wr_new", 32'h0, 32'hCAFE_0000, 1'b0);

    // Back-to-back on B with MAX_OUTSTANDING 2, latency 3
    for (int c = 0; c < 9; c++) begin
      b_req  = (req_t[c] != 0);
      b_addr = BASE_B + 32'(w_t[c] * 4);
      sample;
      chk($sformatf("b2b_gnt_c%0d", c), 32'(b_gnt), 32'(gnt_t[c]));
      chk($sformatf("b2b_rvalid_c%0d", c), 32'(b_rvalid), 32'(rv_t[c]));
      chk($sformatf("b2b_out_c%0d", c), 32'(b_out), 32'(out_t[c]));
      if (gnt_t[c] != 0) exp_q.push_back(32'hB000_0000 + 32'(w_t[c]));
      if (rv_t[c] != 0) begin
        if (exp_q.size() == 0) chk("b2b_q_empty", 32'd1, 32'd0);
        else chk($sformatf("b2b_rdata_c%0d", c), b_rdata, exp_q.pop_front());
      end
      tick;
    end
    b_req = 1'b0;
    chk("b2b_q_drained", 32'(exp_q.size()), 32'd0);

    // B boundaries around a non-zero base
    rd_b("b_lastword", BASE_B + 32'h3C, 32'hBBBB_000F, 1'b0);
    rd_b("b_oor_end", BASE_B + 32'h40, 32'h0, 1'b1);
    rd_b("b_oor_below", BASE_B - 32'h4, 32'h0, 1'b1);

    // Reset with two outstanding requests discards them
    b_req = 1'b1; b_addr = BASE_B + 32'h4;
    sample;
    chk("rstmid_gnt0", 32'(b_gnt), 32'd1);
    tick;
    b_addr = BASE_B + 32'h8;
    sample;
    chk("rstmid_gnt1", 32'(b_gnt), 32'd1);
    tick;
    b_req = 1'b0;
    sample;
    chk("rstmid_out2", 32'(b_out), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rstmid_out0", 32'(b_out), 32'd0);
    chk("rstmid_rvalid", 32'(b_rvalid), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sample;
      chk("rstmid_no_rvalid", 32'(b_rvalid), 32'd0);
      chk("rstmid_out_idle", 32'(b_out), 32'd0);
      tick;
    end
    rd_b("rstmid_mem_kept", BASE_B + 32'h4, 32'hB000_0001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
